// File: rtl/datareq_sched.sv
// Round-robin scheduler sharing the DDR data-request NoC port among NUM_REQ requesters.
// Grants one single-beat request per cycle into a registered output stage, with credit-limited issue.
module datareq_sched #(
  parameter int DATA_WIDTH  = 512,
  parameter int NUM_REQ     = 4,
  parameter int NOC_RADIX   = 16,
  parameter int IDW         = $clog2(NOC_RADIX),
  parameter logic [IDW-1:0] DDR_PORT = 4'd4,
  parameter int MAX_PER_REQ = 8,
  parameter int MAX_TOTAL   = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      i_req_data,
  output logic [NUM_REQ-1:0]                 o_req_ready,
  output logic                               out_valid,
  output logic                               out_sop,
  output logic                               out_eop,
  output logic                               out_error,
  output logic [$clog2(DATA_WIDTH/8)-1:0]    out_empty,
  output logic [DATA_WIDTH-1:0]              out_data,
  input  logic                               out_ready,
  input  logic                               i_resp_done,
  input  logic [$clog2(NUM_REQ)-1:0]         i_resp_src,
  output logic [$clog2(MAX_TOTAL+1)-1:0]     o_outstanding,
  output logic                               o_err
);

  localparam int IW      = $clog2(NUM_REQ);
  localparam int CW      = $clog2(MAX_PER_REQ + 1);
  localparam int TW      = $clog2(MAX_TOTAL + 1);
  localparam int DST_LSB = DATA_WIDTH - 3 - 32 - IDW - IDW + 1;
  localparam logic [CW-1:0] MAX_PER_REQ_C = CW'(MAX_PER_REQ);
  localparam logic [TW-1:0] MAX_TOTAL_C   = TW'(MAX_TOTAL);

  logic [IW-1:0]         last_grant_reg;
  logic [TW-1:0]         total_reg;
  logic                  out_valid_reg;
  logic                  out_sop_reg;
  logic                  out_eop_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic                  err_reg;

  logic [DATA_WIDTH-1:0] req_slice [NUM_REQ];
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    src_hit;
  logic [NUM_REQ-1:0]    cnt_below;
  logic [NUM_REQ-1:0]    cnt_underflow;
  logic [NUM_REQ-1:0]    grant_onehot;
  logic                  grant_any;
  logic [IW-1:0]         grant_idx;
  logic [DATA_WIDTH-1:0] stamped_word;
  logic                  slot_free;
  logic                  total_ok;
  logic                  resp_ok;
  logic                  total_underflow;
  int                    scan_idx;

  assign slot_free = !out_valid_reg || out_ready;
  assign total_ok  = total_reg < MAX_TOTAL_C;
  // Responses naming a requester that does not exist never touch a counter.
  assign resp_ok   = i_resp_done && (|src_hit);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : gen_req
      logic [CW-1:0] cnt_reg;
      logic          inc;
      logic          dec;

      assign req_slice[gi]     = i_req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign src_hit[gi]       = (i_resp_src == IW'(gi));
      assign cnt_below[gi]     = cnt_reg < MAX_PER_REQ_C;
      assign eligible[gi]      = !reset && i_req_valid[gi] && cnt_below[gi] && total_ok && slot_free;
      assign grant_onehot[gi]  = grant_any && (grant_idx == IW'(gi));
      assign inc               = grant_onehot[gi];
      assign dec               = i_resp_done && src_hit[gi];
      assign cnt_underflow[gi] = dec && !inc && (cnt_reg == '0);

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (inc && !dec) begin
          cnt_reg <= cnt_reg + 1'b1;
        end else if (dec && !inc && (cnt_reg != '0)) begin
          cnt_reg <= cnt_reg - 1'b1;
        end
      end
    end
  endgenerate

  // Scan from the requester after the last grant; first eligible wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = int'(last_grant_reg) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!grant_any && eligible[IW'(scan_idx)]) begin
        grant_any = 1'b1;
        grant_idx = IW'(scan_idx);
      end
    end
  end

  always_comb begin
    stamped_word = req_slice[grant_idx];
    stamped_word[DST_LSB +: IDW] = DDR_PORT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_sop_reg   <= 1'b0;
      out_eop_reg   <= 1'b0;
      out_data_reg  <= '0;
    end else if (grant_any) begin
      out_valid_reg <= 1'b1;
      out_sop_reg   <= 1'b1;
      out_eop_reg   <= 1'b1;
      out_data_reg  <= stamped_word;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= IW'(NUM_REQ - 1);
    end else if (grant_any) begin
      last_grant_reg <= grant_idx;
    end
  end

  // A grant and a response in the same cycle cancel out on the global count.
  assign total_underflow = resp_ok && !grant_any && (total_reg == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      total_reg <= '0;
    end else if (grant_any && !resp_ok) begin
      total_reg <= total_reg + 1'b1;
    end else if (resp_ok && !grant_any && (total_reg != '0)) begin
      total_reg <= total_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if ((i_resp_done && !(|src_hit)) || total_underflow || (|cnt_underflow)) begin
      err_reg <= 1'b1;
    end
  end

  assign o_req_ready   = grant_onehot;
  assign out_valid     = out_valid_reg;
  assign out_sop       = out_sop_reg;
  assign out_eop       = out_eop_reg;
  assign out_error     = 1'b0;
  assign out_empty     = '0;
  assign out_data      = out_data_reg;
  assign o_outstanding = total_reg;
  assign o_err         = err_reg;

endmodule

// File: tb/tb_datareq_sched.sv
// Randomized + directed bench for datareq_sched: per-cycle reference model of grants/credits,
// scoreboard queue of expected output beats checked by an independent monitor.
module tb_datareq_sched;

  localparam int DW = 512;
  localparam int NR = 4;

  logic            clk;
  logic            reset;
  logic [NR-1:0]   i_req_valid;
  logic [NR*DW-1:0] i_req_data;
  logic [NR-1:0]   o_req_ready;
  logic            out_valid, out_sop, out_eop, out_error;
  logic [5:0]      out_empty;
  logic [DW-1:0]   out_data;
  logic            out_ready;
  logic            i_resp_done;
  logic [1:0]      i_resp_src;
  logic [4:0]      o_outstanding;
  logic            o_err;

  datareq_sched dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_data(i_req_data), .o_req_ready(o_req_ready),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_error(out_error),
    .out_empty(out_empty), .out_data(out_data), .out_ready(out_ready),
    .i_resp_done(i_resp_done), .i_resp_src(i_resp_src),
    .o_outstanding(o_outstanding), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Request fields: wr, rd, pktid, source, destination, filler (512 bits total).
  logic          f_wr   [NR];
  logic          f_rd   [NR];
  logic [31:0]   f_pkt  [NR];
  logic [3:0]    f_src  [NR];
  logic [3:0]    f_dst  [NR];
  logic [469:0]  f_fill [NR];

  function automatic logic [DW-1:0] beat(logic wr, logic rd, logic [31:0] pkt, logic [3:0] s,
                                         logic [3:0] d, logic [469:0] fill);
    return {wr, rd, pkt, s, d, fill};
  endfunction

  always_comb begin
    i_req_data = '0;
    for (int i = 0; i < NR; i++)
      i_req_data[i*DW +: DW] = beat(f_wr[i], f_rd[i], f_pkt[i], f_src[i], f_dst[i], f_fill[i]);
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];

  // Reference model state
  int m_cnt [NR];
  int m_total;
  int m_last;
  bit m_oval;
  bit m_err;

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rand_fields(int i);
    logic [479:0] t;
    for (int w = 0; w < 15; w++) t[w*32 +: 32] = $urandom();
    f_fill[i] = t[469:0];
    f_wr[i]   = 1'($urandom_range(1));
    f_rd[i]   = 1'($urandom_range(1));
    f_pkt[i]  = $urandom();
    f_src[i]  = 4'($urandom_range(15));
    f_dst[i]  = 4'($urandom_range(15));
  endtask

  task automatic rand_all();
    for (int i = 0; i < NR; i++) rand_fields(i);
  endtask

  // One clock: compare DUT against the model at the negedge, advance the model, return after posedge.
  task automatic cycle();
    int g;
    int rs;
    bit slot;
    logic [NR-1:0] exp_rdy;
    @(negedge clk);
    g = -1;
    exp_rdy = '0;
    if (!reset) begin
      slot = !m_oval || out_ready;
      if (slot && m_total < 16) begin
        for (int k = 1; k <= NR; k++) begin
          int idx;
          idx = (m_last + k) % NR;
          if (g < 0 && i_req_valid[idx] && m_cnt[idx] < 8) g = idx;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    check("ready", DW'(o_req_ready), DW'(exp_rdy));
    check("outstanding", DW'(o_outstanding), DW'(m_total));
    check("err", DW'(o_err), DW'(m_err));
    check("out_valid", DW'(out_valid), DW'(m_oval));
    if (reset) begin
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
      m_total = 0; m_last = NR - 1; m_oval = 0; m_err = 0;
      exp_q.delete();
    end else begin
      rs = int'(i_resp_src);
      if (g >= 0) exp_q.push_back(beat(f_wr[g], f_rd[g], f_pkt[g], f_src[g], 4'd4, f_fill[g]));
      if (g >= 0 && !(i_resp_done && rs == g)) m_cnt[g]++;
      if (i_resp_done && rs != g) begin
        if (m_cnt[rs] == 0) m_err = 1; else m_cnt[rs]--;
      end
      if (g >= 0 && !i_resp_done) m_total++;
      else if (g < 0 && i_resp_done) begin
        if (m_total == 0) m_err = 1; else m_total--;
      end
      if (g >= 0) begin m_oval = 1; m_last = g; end
      else if (out_ready) m_oval = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic respond(int src, int times);
    i_req_valid = '0;
    for (int r = 0; r < times; r++) begin
      i_resp_done = 1'b1; i_resp_src = 2'(src);
      cycle();
    end
    i_resp_done = 1'b0;
  endtask

  // Monitor: every beat the NoC takes is matched against the oldest expected beat.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL beat_unexpected: got %0h expected none", out_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        check("beat_data", out_data, e);
        check("beat_flags", DW'({out_sop, out_eop, out_error, out_empty}), DW'({1'b1, 1'b1, 1'b0, 6'd0}));
      end
    end
  end

  initial begin
    reset = 1'b1; i_req_valid = '0; out_ready = 1'b1; i_resp_done = 1'b0; i_resp_src = '0;
    rand_all();
    repeat (3) cycle();
    reset = 1'b0;

    // Requester 2 alone, pktid 0xAB
    f_pkt[2] = 32'h0000_00AB;
    i_req_valid = 4'b0100;
    cycle();
    i_req_valid = '0;
    check("t1_pkt", DW'(out_data[509:478]), DW'(32'hAB));
    check("t1_dst", DW'(out_data[473:470]), DW'(4'd4));
    check("t1_total", DW'(o_outstanding), DW'(1));
    cycle();
    respond(2, 1);

    // All requesters continuously valid until the global limit is hit
    i_req_valid = 4'b1111;
    for (int c = 0; c < 20; c++) begin rand_all(); cycle(); end
    check("t2_total", DW'(o_outstanding), DW'(16));
    for (int r = 0; r < 16; r++) respond(r % NR, 1);

    // Requester 1 alone hits its per-requester limit, then one credit returns
    i_req_valid = 4'b0010;
    for (int c = 0; c < 10; c++) begin rand_fields(1); cycle(); end
    check("t3_total", DW'(o_outstanding), DW'(8));
    i_resp_done = 1'b1; i_resp_src = 2'd1;
    cycle();
    i_resp_done = 1'b0;
    cycle();
    check("t3_resume", DW'(o_outstanding), DW'(8));
    respond(1, 8);

    // Backpressure: one beat latched and held stable
    out_ready = 1'b0;
    i_req_valid = 4'b0001;
    rand_fields(0);
    cycle();
    for (int c = 0; c < 5; c++) begin
      rand_fields(0);
      check("t4_hold", out_data, (exp_q.size() > 0) ? exp_q[0] : '0);
      cycle();
    end
    i_req_valid = '0; out_ready = 1'b1;
    cycle(); cycle();
    respond(0, 1);

    // Grant and response on requester 3 in the same cycle with cnt[3]=2
    i_req_valid = 4'b1000;
    cycle(); rand_fields(3); cycle();
    i_req_valid = 4'b1000; rand_fields(3);
    i_resp_done = 1'b1; i_resp_src = 2'd3;
    cycle();
    i_resp_done = 1'b0; i_req_valid = '0;
    check("t5_total", DW'(o_outstanding), DW'(2));
    respond(3, 2);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      int s;
      rand_all();
      i_req_valid = 4'($urandom_range(15));
      out_ready = ($urandom_range(9) < 7);
      s = $urandom_range(NR - 1);
      i_resp_done = ($urandom_range(9) < 4) && (m_cnt[s] > 0);
      i_resp_src = 2'(s);
      cycle();
    end
    i_resp_done = 1'b0; out_ready = 1'b1; i_req_valid = '0;
    cycle(); cycle();
    for (int i = 0; i < NR; i++) respond(i, m_cnt[i]);
    check("rand_drained", DW'(o_outstanding), DW'(0));

    // Credit underflow is sticky; reset mid-stream clears everything
    respond(0, 1);
    check("t6_err", DW'(o_err), DW'(1));
    i_req_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin rand_all(); cycle(); end
    out_ready = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0; i_req_valid = '0; out_ready = 1'b1;
    check("t6_valid", DW'(out_valid), DW'(0));
    check("t6_total", DW'(o_outstanding), DW'(0));
    check("t6_err_clr", DW'(o_err), DW'(0));
    cycle(); cycle();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_empty: got %0d pending beats expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/datareq_sched.md
# datareq_sched

Round-robin scheduler that shares the single DDR data-request NoC port among `NUM_REQ` packet-recombine requesters. Each requester emits single-beat read requests (write flag, read flag, 32-bit packet id, source node id). The scheduler grants one request per cycle into a registered output stage and stamps the DDR destination field. It enforces per-requester and global limits on outstanding requests, with credits returned by DDR responses. It sits between the recombine data-request outputs and the NoC router port facing the DDR node.

## Interface

Parameters:

- `DATA_WIDTH`, 512, request beat width.
- `NUM_REQ`, 4, number of requesters (≥2).
- `NOC_RADIX`, 16, NoC node count; `IDW = $clog2(NOC_RADIX)`.
- `DDR_PORT`, 4'd4, destination node id stamped into every request.
- `MAX_PER_REQ`, 8, max outstanding requests per requester.
- `MAX_TOTAL`, 16, max outstanding requests overall.

Ports:

- `clk`, in, 1, single clock.
- `reset`, in, 1, synchronous, active-high.
- `i_req_valid`, in, NUM_REQ, per-requester request valid.
- `i_req_data`, in, NUM_REQ*DATA_WIDTH, requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `o_req_ready`, out, NUM_REQ, one-hot grant; a request is accepted when valid & ready.
- `out.valid/sop/eop/error/empty/data`, out, avalonST src, granted request to NoC.
- `out.ready`, in, 1, NoC backpressure.
- `i_resp_done`, in, 1, a DDR response for one outstanding request has been consumed.
- `i_resp_src`, in, $clog2(NUM_REQ), requester index owning that response.
- `o_outstanding`, out, $clog2(MAX_TOTAL+1), global outstanding count.
- `o_err`, out, 1, sticky credit underflow flag.

## Operation

- Output slot is free when `!out.valid || out.ready`.
- Requester i is eligible when all three hold: `i_req_valid[i]`; `cnt[i] < MAX_PER_REQ`; `total < MAX_TOTAL`.
- Arbitration:
  - Round-robin starting at `(last_grant+1) mod NUM_REQ`.
  - The first eligible requester is granted, only if the slot is free.
  - `o_req_ready` is combinational from the current valids, counters, pointer and `out.ready`.
  - At most one bit is set.
- On grant i:
  - Output register loads `i_req_data[i]` with bits [DATA_WIDTH-3-32-IDW -: IDW] overwritten by `DDR_PORT` (destination field below source id).
  - `sop=eop=1`, `error=0`, `empty=0`, `valid=1`.
  - `last_grant<=i`; `cnt[i]++`; `total++`.
- The output holds stable while `out.valid && !out.ready`.
- `valid` clears when the beat is taken with no new grant.
- On `i_resp_done`:
  - `cnt[i_resp_src]--`; `total--`.
  - If either counter is already 0: that counter holds at 0 and `o_err<=1` (sticky until reset).
  - `i_resp_src ≥ NUM_REQ` sets `o_err` and changes no counter.
- Grant and response on the same requester in the same cycle: that `cnt` is unchanged and `total` is unchanged.
- Grant and response on different requesters in the same cycle: each `cnt` moves by its own event and `total` is unchanged.
- Counter widths: `cnt` is $clog2(MAX_PER_REQ+1) bits; `total` matches `o_outstanding`. No wrap is possible given the eligibility gating.
- Reset: `out.valid=0`, all data/flags 0, `last_grant=NUM_REQ-1` (so requester 0 has first priority), counters 0, `o_err=0`, `o_req_ready=0` during reset.
- Reset mid-operation: any pending output beat is dropped and all credits are cleared. Requesters re-issue as their own logic dictates.

## Timing

- Latency: request accepted in cycle N → `out.valid` in cycle N+1.
- Throughput: 1 request/cycle while `out.ready=1` and credits are available.
- Credit return in cycle N affects eligibility in cycle N+1 (counters are registered).
- `o_outstanding` reflects the registered `total`.
- Fairness: with all requesters continuously eligible, each is granted exactly once in every NUM_REQ consecutive grants.

## Test plan

- Reset, then requester 2 alone sends pktid 0x0000_00AB → `o_req_ready=4'b0100` that cycle; next cycle `out.valid=1`, `sop=eop=1`, destination field=4, pktid field=0xAB, `o_outstanding=1`.
- All 4 requesters valid continuously, `out.ready=1`, no responses → grants in order 0,1,2,3,0,1,2,3…; after 16 grants `o_outstanding=16` and all ready bits are 0.
- Requester 1 alone issues 8 requests with no responses → 9th request stalls (ready=0). A single `i_resp_done` with src=1 → grant resumes on the following cycle.
- `out.ready=0` for 5 cycles with requester 0 valid → exactly one beat is latched; `out.data` is stable; `o_req_ready=0`; one beat emitted when ready rises.
- Same cycle: grant to requester 3 and `i_resp_done` with src=3, with `cnt[3]=2` → `cnt[3]` stays 2 and `o_outstanding` is unchanged.
- `i_resp_done` with src=0 when `cnt[0]=0` → `o_err=1` and stays 1; counters remain 0. Assert `reset` mid-stream → `out.valid=0`, `o_outstanding=0`, `o_err=0` on the next cycle.
